// File: rtl/mini_alu_pkg.sv
// Shared definitions for the mini-ALU control path: opcodes, FSM states,
// ALU function codes and the decoder output bundle.
package mini_alu_pkg;

  localparam logic [3:0] OPC_NOP  = 4'h0;
  localparam logic [3:0] OPC_ADD  = 4'h1;
  localparam logic [3:0] OPC_SUB  = 4'h2;
  localparam logic [3:0] OPC_AND  = 4'h3;
  localparam logic [3:0] OPC_OR   = 4'h4;
  localparam logic [3:0] OPC_LDA  = 4'h5;
  localparam logic [3:0] OPC_LDB  = 4'h6;
  localparam logic [3:0] OPC_SKZ  = 4'h7;
  localparam logic [3:0] OPC_HALT = 4'hF;

  localparam logic [2:0] ALU_NONE = 3'd0;
  localparam logic [2:0] ALU_ADD  = 3'd1;
  localparam logic [2:0] ALU_SUB  = 3'd2;
  localparam logic [2:0] ALU_AND  = 3'd3;
  localparam logic [2:0] ALU_OR   = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_START   = 3'd1,
    ST_FETCH   = 3'd2,
    ST_DECODE  = 3'd3,
    ST_EXECUTE = 3'd4,
    ST_ADVANCE = 3'd5,
    ST_HALT    = 3'd6
  } state_t;

  typedef struct packed {
    logic       is_alu;
    logic       is_lda;
    logic       is_ldb;
    logic       is_skz;
    logic       is_halt;
    logic       illegal;
    logic [2:0] alu_op;
  } dec_t;

endpackage

// File: rtl/mini_alu_decoder.sv
// Combinational opcode decoder: one-hot instruction class flags plus the
// ALU function code (zero unless the opcode is an ALU operation).
module mini_alu_decoder
  import mini_alu_pkg::*;
(
  input  logic [3:0] i_opcode,
  output dec_t       o_dec
);

  always_comb begin
    o_dec = '0;
    case (i_opcode)
      OPC_NOP:  ;
      OPC_ADD:  begin o_dec.is_alu = 1'b1; o_dec.alu_op = ALU_ADD; end
      OPC_SUB:  begin o_dec.is_alu = 1'b1; o_dec.alu_op = ALU_SUB; end
      OPC_AND:  begin o_dec.is_alu = 1'b1; o_dec.alu_op = ALU_AND; end
      OPC_OR:   begin o_dec.is_alu = 1'b1; o_dec.alu_op = ALU_OR;  end
      OPC_LDA:  o_dec.is_lda  = 1'b1;
      OPC_LDB:  o_dec.is_ldb  = 1'b1;
      OPC_SKZ:  o_dec.is_skz  = 1'b1;
      OPC_HALT: o_dec.is_halt = 1'b1;
      default:  o_dec.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/mini_alu_sequencer.sv
// Control FSM for the mini-ALU: fetch/decode/execute/advance sequencing of
// PC and register-bank enables, with stall timeout and retire counting.
module mini_alu_sequencer
  import mini_alu_pkg::*;
#(
  parameter int INSTR_W     = 16,
  parameter int RETIRE_W    = 16,
  parameter int STALL_LIMIT = 15
) (
  input  logic                Clock,
  input  logic                Reset,
  input  logic                iStart,
  input  logic                iStall,
  input  logic [INSTR_W-1:0]  iInstr,
  input  logic                iZero,
  output logic                oPCReset,
  output logic                oPCEnable,
  output logic                oIREnable,
  output logic                oOpAEnable,
  output logic                oOpBEnable,
  output logic                oResultEnable,
  output logic [2:0]          oAluOp,
  output logic                oBusy,
  output logic                oHalted,
  output logic                oIllegal,
  output logic                oFault,
  output logic [RETIRE_W-1:0] oRetired,
  output logic [2:0]          oDbgState
);

  localparam int STALL_W = $clog2(STALL_LIMIT + 1);

  state_t              r_state;
  logic [3:0]          r_opcode;
  logic [STALL_W-1:0]  r_stall_cnt;
  logic [RETIRE_W-1:0] r_retired;
  logic                r_fault;
  dec_t                w_dec;
  logic                w_unused_instr;

  assign w_unused_instr = ^iInstr[INSTR_W-5:0];

  mini_alu_decoder u_decoder (
    .i_opcode (r_opcode),
    .o_dec    (w_dec)
  );

  // iStall acts as the instruction memory's not-ready: the word on iInstr is
  // accepted (and the IR loaded) only in a FETCH cycle where iStall is low.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_state     <= ST_IDLE;
      r_opcode    <= 4'h0;
      r_stall_cnt <= '0;
      r_retired   <= '0;
      r_fault     <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE, ST_HALT: begin
          if (iStart) r_state <= ST_START;
        end
        ST_START: begin
          r_retired   <= '0;
          r_fault     <= 1'b0;
          r_stall_cnt <= '0;
          r_state     <= ST_FETCH;
        end
        ST_FETCH: begin
          if (!iStall) begin
            r_opcode    <= iInstr[INSTR_W-1 -: 4];
            r_stall_cnt <= '0;
            r_state     <= ST_DECODE;
          end else if (r_stall_cnt == STALL_W'(STALL_LIMIT - 1)) begin
            r_stall_cnt <= '0;
            r_fault     <= 1'b1;
            r_state     <= ST_HALT;
          end else begin
            r_stall_cnt <= r_stall_cnt + STALL_W'(1);
          end
        end
        ST_DECODE: begin
          r_state <= w_dec.is_halt ? ST_HALT : ST_EXECUTE;
        end
        ST_EXECUTE: r_state <= ST_ADVANCE;
        ST_ADVANCE: begin
          r_retired <= r_retired + RETIRE_W'(1);
          r_state   <= ST_FETCH;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Strobes decode straight from the registered state so reset clears them at once.
  always_comb begin
    oPCReset      = 1'b0;
    oPCEnable     = 1'b0;
    oIREnable     = 1'b0;
    oOpAEnable    = 1'b0;
    oOpBEnable    = 1'b0;
    oResultEnable = 1'b0;
    oAluOp        = ALU_NONE;
    oIllegal      = 1'b0;
    case (r_state)
      ST_START:   oPCReset = 1'b1;
      ST_FETCH:   oIREnable = !iStall;
      ST_DECODE:  oIllegal = w_dec.illegal;
      ST_EXECUTE: begin
        oResultEnable = w_dec.is_alu;
        oAluOp        = w_dec.is_alu ? w_dec.alu_op : ALU_NONE;
        oOpAEnable    = w_dec.is_lda;
        oOpBEnable    = w_dec.is_ldb;
        oPCEnable     = w_dec.is_skz & iZero;
      end
      ST_ADVANCE: oPCEnable = 1'b1;
      default: ;
    endcase
  end

  assign oBusy     = (r_state != ST_IDLE) && (r_state != ST_HALT);
  assign oHalted   = (r_state == ST_HALT);
  assign oFault    = r_fault;
  assign oRetired  = r_retired;
  assign oDbgState = r_state;

endmodule

// File: tb/tb_mini_alu_sequencer.sv
// Directed bench for mini_alu_sequencer: per-cycle strobe vectors checked
// against hand-computed expectations.
module tb_mini_alu_sequencer;

  logic        Clock;
  logic        Reset;
  logic        iStart;
  logic        iStall;
  logic [15:0] iInstr;
  logic        iZero;
  logic        oPCReset, oPCEnable, oIREnable, oOpAEnable, oOpBEnable;
  logic        oResultEnable, oBusy, oHalted, oIllegal, oFault;
  logic [2:0]  oAluOp;
  logic [15:0] oRetired;
  logic [2:0]  oDbgState;

  int n_checks;
  int n_fail;

  // {PCReset, PCEnable, IREnable, OpA, OpB, Result, AluOp[2:0], Busy, Halted, Illegal, Fault}
  logic [12:0] w_vec;
  assign w_vec = {oPCReset, oPCEnable, oIREnable, oOpAEnable, oOpBEnable,
                  oResultEnable, oAluOp, oBusy, oHalted, oIllegal, oFault};

  localparam logic [12:0] PCR  = 13'h1000;
  localparam logic [12:0] PCE  = 13'h0800;
  localparam logic [12:0] IR   = 13'h0400;
  localparam logic [12:0] OPA  = 13'h0200;
  localparam logic [12:0] OPB  = 13'h0100;
  localparam logic [12:0] RES  = 13'h0080;
  localparam logic [12:0] AOP1 = 13'h0010;
  localparam logic [12:0] AOP2 = 13'h0020;
  localparam logic [12:0] BSY  = 13'h0008;
  localparam logic [12:0] HLT  = 13'h0004;
  localparam logic [12:0] ILL  = 13'h0002;
  localparam logic [12:0] FLT  = 13'h0001;

  mini_alu_sequencer dut (
    .Clock         (Clock),
    .Reset         (Reset),
    .iStart        (iStart),
    .iStall        (iStall),
    .iInstr        (iInstr),
    .iZero         (iZero),
    .oPCReset      (oPCReset),
    .oPCEnable     (oPCEnable),
    .oIREnable     (oIREnable),
    .oOpAEnable    (oOpAEnable),
    .oOpBEnable    (oOpBEnable),
    .oResultEnable (oResultEnable),
    .oAluOp        (oAluOp),
    .oBusy         (oBusy),
    .oHalted       (oHalted),
    .oIllegal      (oIllegal),
    .oFault        (oFault),
    .oRetired      (oRetired),
    .oDbgState     (oDbgState)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Called 2 time units after a rising edge: drive inputs, check, advance one cycle.
  task automatic cyc(input string tag, input logic st, input logic stall,
                     input logic zero, input logic [15:0] instr, input logic [12:0] exp);
    iStart = st;
    iStall = stall;
    iZero  = zero;
    iInstr = instr;
    #1;
    check_eq(tag, 32'(w_vec), 32'(exp));
    @(posedge Clock);
    #2;
  endtask

  task automatic run_instr(input string tag, input logic [15:0] instr, input logic zero,
                           input logic [12:0] exp_dec, input logic [12:0] exp_exec);
    cyc({tag, "_fetch"}, 1'b0, 1'b0, zero, instr, IR | BSY);
    cyc({tag, "_dec"},   1'b0, 1'b0, zero, instr, exp_dec);
    cyc({tag, "_exec"},  1'b0, 1'b0, zero, instr, exp_exec);
    cyc({tag, "_adv"},   1'b0, 1'b0, zero, instr, PCE | BSY);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    Reset  = 1'b1;
    iStart = 1'b0;
    iStall = 1'b0;
    iInstr = 16'h0000;
    iZero  = 1'b0;
    repeat (2) @(posedge Clock);
    #2;
    check_eq("rst_vec", 32'(w_vec), 32'h0);
    check_eq("rst_retired", 32'(oRetired), 32'h0);
    Reset = 1'b0;

    // single ADD from reset
    cyc("t1_idle", 1'b1, 1'b0, 1'b0, 16'h1000, 13'h0);
    cyc("t1_start", 1'b0, 1'b0, 1'b0, 16'h1000, PCR | BSY);
    run_instr("t1_add", 16'h1000, 1'b0, BSY, RES | AOP1 | BSY);
    check_eq("t1_retired", 32'(oRetired), 32'd1);

    // ADD with three stalled FETCH cycles
    for (int i = 0; i < 3; i++) cyc("t2_stall", 1'b0, 1'b1, 1'b0, 16'h1000, BSY);
    run_instr("t2_add", 16'h1000, 1'b0, BSY, RES | AOP1 | BSY);
    check_eq("t2_retired", 32'(oRetired), 32'd2);

    // SKZ taken, then not taken (iStart during DECODE must be ignored)
    run_instr("t3_skz1", 16'h7000, 1'b1, BSY, PCE | BSY);
    check_eq("t3_retired1", 32'(oRetired), 32'd3);
    cyc("t3_skz0_fetch", 1'b0, 1'b0, 1'b0, 16'h7000, IR | BSY);
    cyc("t3_skz0_dec",   1'b1, 1'b0, 1'b0, 16'h7000, BSY);
    cyc("t3_skz0_exec",  1'b0, 1'b0, 1'b0, 16'h7000, BSY);
    cyc("t3_skz0_adv",   1'b0, 1'b0, 1'b0, 16'h7000, PCE | BSY);
    check_eq("t3_retired0", 32'(oRetired), 32'd4);

    // HALT, stay halted, restart
    cyc("h_fetch", 1'b0, 1'b0, 1'b0, 16'hF000, IR | BSY);
    cyc("h_dec",   1'b0, 1'b0, 1'b0, 16'hF000, BSY);
    check_eq("h_retired", 32'(oRetired), 32'd4);
    cyc("h_hold",  1'b0, 1'b0, 1'b0, 16'hF000, HLT);
    cyc("h_halt",  1'b1, 1'b0, 1'b0, 16'hF000, HLT);
    cyc("h_start", 1'b0, 1'b0, 1'b0, 16'h5000, PCR | BSY);
    check_eq("h_retired_clr", 32'(oRetired), 32'd0);

    // program LDA, LDB, SUB, HALT
    run_instr("t4_lda", 16'h5000, 1'b0, BSY, OPA | BSY);
    run_instr("t4_ldb", 16'h6000, 1'b0, BSY, OPB | BSY);
    run_instr("t4_sub", 16'h2000, 1'b0, BSY, RES | AOP2 | BSY);
    cyc("t4_hfetch", 1'b0, 1'b0, 1'b0, 16'hF000, IR | BSY);
    cyc("t4_hdec",   1'b0, 1'b0, 1'b0, 16'hF000, BSY);
    check_eq("t4_retired", 32'(oRetired), 32'd3);
    cyc("t4_halt",   1'b1, 1'b0, 1'b0, 16'hF000, HLT);
    cyc("t4_start",  1'b0, 1'b0, 1'b0, 16'h9000, PCR | BSY);
    check_eq("t4_retired_clr", 32'(oRetired), 32'd0);

    // illegal opcode, then stall timeout
    run_instr("t5_ill", 16'h9000, 1'b0, BSY | ILL, BSY);
    check_eq("t5_retired", 32'(oRetired), 32'd1);
    for (int i = 0; i < 15; i++) cyc("t5_stall", 1'b0, 1'b1, 1'b0, 16'h1000, BSY);
    cyc("t5_fault", 1'b0, 1'b1, 1'b0, 16'h1000, HLT | FLT);
    check_eq("t5_retired_keep", 32'(oRetired), 32'd1);
    cyc("t5_restart", 1'b1, 1'b0, 1'b0, 16'h0000, HLT | FLT);
    cyc("t5_start",   1'b0, 1'b0, 1'b0, 16'h0000, PCR | BSY | FLT);

    // fault cleared; NOP retires; reset in the middle of an ADD
    run_instr("t6_nop", 16'h0000, 1'b0, BSY, BSY);
    check_eq("t6_retired_nop", 32'(oRetired), 32'd1);
    cyc("t6_fetch", 1'b0, 1'b0, 1'b0, 16'h1000, IR | BSY);
    cyc("t6_dec",   1'b0, 1'b0, 1'b0, 16'h1000, BSY);
    #1;
    check_eq("t6_exec", 32'(w_vec), 32'(RES | AOP1 | BSY));
    Reset = 1'b1;
    #1;
    check_eq("t6_rst_vec", 32'(w_vec), 32'h0);
    check_eq("t6_rst_retired", 32'(oRetired), 32'd0);
    @(posedge Clock);
    #2;
    Reset = 1'b0;
    cyc("t6_idle",  1'b1, 1'b0, 1'b0, 16'h1000, 13'h0);
    cyc("t6_start", 1'b0, 1'b0, 1'b0, 16'h1000, PCR | BSY);
    run_instr("t6_add", 16'h1000, 1'b0, BSY, RES | AOP1 | BSY);
    check_eq("t6_retired", 32'(oRetired), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
